// File: rtl/psum_drain.sv
`default_nettype none
// ============================================================================
//  Module      : psum_drain
//  Description : Snapshot-and-stream drain for the 16-lane MAC accumulator
//                array. A start request copies the whole partial-sum latch
//                array into a local snapshot, then streams one slot per beat
//                (all lanes side by side) over a valid/ready interface.
//  Options     : PSUM_DRAIN_RELU_EN - when defined, negative lane values are
//                replaced by zero on the output (snapshot is left untouched).
//  Revision    : 1.0 - initial release
// ============================================================================
module psum_drain #(
  parameter int LANES  = 16,
  parameter int SLOTS  = 16,
  parameter int PSUM_W = 24
) (
  input  logic                            clk,
  input  logic                            rst_n,
  input  logic [LANES*SLOTS*PSUM_W-1:0]   latch_array_in,
  input  logic                            drain_start,
  output logic                            drain_busy,
  output logic                            out_valid,
  input  logic                            out_ready,
  output logic [LANES*PSUM_W-1:0]         out_data,
  output logic [$clog2(SLOTS)-1:0]        out_slot,
  output logic                            out_last,
  output logic                            drain_done
);

  localparam int SLOT_W = $clog2(SLOTS);
  localparam int LANE_W = SLOTS * PSUM_W;
  localparam int ARR_W  = LANES * LANE_W;
  localparam int BEAT_W = LANES * PSUM_W;
  localparam logic [SLOT_W-1:0] C_LAST_SLOT = SLOT_W'(SLOTS - 1);

  typedef enum logic [0:0] {
    ST_IDLE   = 1'b0,
    ST_STREAM = 1'b1
  } state_t;

  state_t              state_q, state_d;
  logic [ARR_W-1:0]    snap_q,  snap_d;
  logic [SLOT_W-1:0]   slot_q,  slot_d;
  logic                last_q,  last_d;
  logic                done_q,  done_d;
  logic [BEAT_W-1:0]   data_q,  data_d;

  // Slot whose contents become the next registered beat: slot 0 of the live
  // array when starting, otherwise the following slot of the snapshot.
  logic                src_live;
  logic [SLOT_W-1:0]   sel_slot;
  logic [BEAT_W-1:0]   next_beat;

  assign src_live = (state_q == ST_IDLE);
  assign sel_slot = src_live ? '0 : (slot_q + 1'b1);

  generate
    for (genvar j = 0; j < LANES; j++) begin : g_lane
      logic [PSUM_W-1:0] lane_src;

      // Pick this lane's value for the selected slot from live array or snapshot
      always_comb begin
        lane_src = '0;
        if (src_live) begin
          lane_src = latch_array_in[j*LANE_W + int'(sel_slot)*PSUM_W +: PSUM_W];
        end else begin
          lane_src = snap_q[j*LANE_W + int'(sel_slot)*PSUM_W +: PSUM_W];
        end
      end

`ifdef PSUM_DRAIN_RELU_EN
      assign next_beat[j*PSUM_W +: PSUM_W] = lane_src[PSUM_W-1] ? '0 : lane_src;
`else
      assign next_beat[j*PSUM_W +: PSUM_W] = lane_src;
`endif
    end
  endgenerate

  // Next-state and next-output logic; the beat register only moves on start
  // or on an accepted transfer so the payload holds still under backpressure.
  always_comb begin
    state_d = state_q;
    snap_d  = snap_q;
    slot_d  = slot_q;
    last_d  = last_q;
    done_d  = 1'b0;
    data_d  = data_q;
    case (state_q)
      ST_IDLE: begin
        if (drain_start) begin
          state_d = ST_STREAM;
          snap_d  = latch_array_in;
          slot_d  = '0;
          last_d  = (C_LAST_SLOT == '0);
          data_d  = next_beat;
        end
      end
      ST_STREAM: begin
        if (out_ready) begin
          if (last_q) begin
            state_d = ST_IDLE;
            last_d  = 1'b0;
            done_d  = 1'b1;
          end else begin
            slot_d  = slot_q + 1'b1;
            last_d  = ((slot_q + 1'b1) == C_LAST_SLOT);
            data_d  = next_beat;
          end
        end
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  // State, snapshot and output registers; a reset mid-stream discards the drain
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= ST_IDLE;
      snap_q  <= '0;
      slot_q  <= '0;
      last_q  <= 1'b0;
      done_q  <= 1'b0;
      data_q  <= '0;
    end else begin
      state_q <= state_d;
      snap_q  <= snap_d;
      slot_q  <= slot_d;
      last_q  <= last_d;
      done_q  <= done_d;
      data_q  <= data_d;
    end
  end

  assign drain_busy = (state_q == ST_STREAM);
  assign out_valid  = (state_q == ST_STREAM);
  assign out_data   = data_q;
  assign out_slot   = slot_q;
  assign out_last   = last_q;
  assign drain_done = done_q;

endmodule
`default_nettype wire

// File: tb/tb_psum_drain.sv
`default_nettype none
// ============================================================================
//  Module      : tb_psum_drain
//  Description : Directed self-checking bench for psum_drain.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_psum_drain;

  localparam int LANES  = 16;
  localparam int SLOTS  = 16;
  localparam int PSUM_W = 24;

  logic                          clk = 1'b0;
  logic                          rst_n;
  logic [LANES*SLOTS*PSUM_W-1:0] latch_array_in;
  logic                          drain_start;
  logic                          drain_busy;
  logic                          out_valid;
  logic                          out_ready;
  logic [LANES*PSUM_W-1:0]       out_data;
  logic [3:0]                    out_slot;
  logic                          out_last;
  logic                          drain_done;

  int pass_cnt  = 0;
  int total_cnt = 0;

  bit [23:0] mdl [16][16];

  always #5 clk = ~clk;

  psum_drain #(.LANES(LANES), .SLOTS(SLOTS), .PSUM_W(PSUM_W)) dut (
    .clk            (clk),
    .rst_n          (rst_n),
    .latch_array_in (latch_array_in),
    .drain_start    (drain_start),
    .drain_busy     (drain_busy),
    .out_valid      (out_valid),
    .out_ready      (out_ready),
    .out_data       (out_data),
    .out_slot       (out_slot),
    .out_last       (out_last),
    .drain_done     (drain_done)
  );

  task automatic chk(input string tag, input logic [383:0] obs, input logic [383:0] exp);
    total_cnt++;
    assert (obs === exp) pass_cnt++;
    else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic pack();
    for (int j = 0; j < 16; j++)
      for (int s = 0; s < 16; s++)
        latch_array_in[j*384 + s*24 +: 24] = mdl[j][s];
  endtask

  function automatic logic [383:0] exp_beat(input int s);
    logic [383:0] e;
    logic [23:0]  v;
    e = '0;
    for (int j = 0; j < 16; j++) begin
      v = mdl[j][s];
`ifdef PSUM_DRAIN_RELU_EN
      if (v[23]) v = 24'h0;
`endif
      e[j*24 +: 24] = v;
    end
    return e;
  endfunction

  task automatic chk_beat(input string tag, input int s);
    chk($sformatf("%s_valid_%0d", tag, s), out_valid, 1);
    chk($sformatf("%s_busy_%0d", tag, s), drain_busy, 1);
    chk($sformatf("%s_slot_%0d", tag, s), out_slot, s);
    chk($sformatf("%s_last_%0d", tag, s), out_last, (s == 15));
    chk($sformatf("%s_data_%0d", tag, s), out_data, exp_beat(s));
  endtask

  // Starts a drain, streams all 16 beats with out_ready high, checks done.
  task automatic stream_all(input string tag, input bit pulse_start, input bit relu_lanes);
    drain_start = 1'b1;
    out_ready   = 1'b1;
    tick();
    drain_start = 1'b0;
    if (pulse_start) latch_array_in = '1;
    for (int s = 0; s < 16; s++) begin
      drain_start = pulse_start && (s == 5 || s == 10);
      @(negedge clk);
      chk_beat(tag, s);
      if (relu_lanes && s == 2) begin
`ifdef PSUM_DRAIN_RELU_EN
        chk("relu_lane3", out_data[3*24 +: 24], 24'h000000);
`else
        chk("relu_lane3", out_data[3*24 +: 24], 24'h800001);
`endif
        chk("relu_lane4", out_data[4*24 +: 24], 24'h000005);
      end
      tick();
    end
    drain_start = 1'b0;
    @(negedge clk);
    chk({tag, "_done"}, drain_done, 1);
    chk({tag, "_valid_after"}, out_valid, 0);
    chk({tag, "_busy_after"}, drain_busy, 0);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int beats;
    int c;
    bit pat [4];
    pat = '{1'b1, 1'b0, 1'b0, 1'b1};

    rst_n          = 1'b0;
    drain_start    = 1'b0;
    out_ready      = 1'b0;
    latch_array_in = '0;

    // Reset state
    tick();
    tick();
    @(negedge clk);
    chk("rst_valid", out_valid, 0);
    chk("rst_data", out_data, 0);
    tick();
    rst_n     = 1'b1;
    out_ready = 1'b1;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      chk($sformatf("idle_valid_%0d", i), out_valid, 0);
      chk($sformatf("idle_busy_%0d", i), drain_busy, 0);
      chk($sformatf("idle_done_%0d", i), drain_done, 0);
      chk($sformatf("idle_last_%0d", i), out_last, 0);
      chk($sformatf("idle_slot_%0d", i), out_slot, 0);
      chk($sformatf("idle_data_%0d", i), out_data, 0);
      tick();
    end

    // Basic drain: lane j slot s = j*16+s
    for (int j = 0; j < 16; j++)
      for (int s = 0; s < 16; s++)
        mdl[j][s] = 24'(j*16 + s);
    pack();
    stream_all("basic", 1'b0, 1'b0);

    // Back-to-back start issued in the drain_done cycle, then backpressure
    drain_start = 1'b1;
    tick();
    drain_start = 1'b0;
    beats = 0;
    c     = 0;
    while (beats < 16 && c < 200) begin
      out_ready = pat[c % 4];
      @(negedge clk);
      if (c == 0) chk("bp_done_cleared", drain_done, 0);
      chk_beat("bp", beats);
      if (out_ready) beats++;
      tick();
      c++;
    end
    chk("bp_beat_count", beats, 16);
    @(negedge clk);
    chk("bp_done", drain_done, 1);
    chk("bp_valid_after", out_valid, 0);
    tick();
    @(negedge clk);
    chk("bp_done_one_cycle", drain_done, 0);

    // Snapshot isolation with start pulses mid-stream
    for (int j = 0; j < 16; j++)
      for (int s = 0; s < 16; s++)
        mdl[j][s] = 24'h100000 | 24'(j*16 + s);
    pack();
    stream_all("iso", 1'b1, 1'b0);
    tick();
    @(negedge clk);
    chk("iso_no_queued_start", out_valid, 0);
    chk("iso_done_one_cycle", drain_done, 0);

    // Mid-stream reset after beat 7
    for (int j = 0; j < 16; j++)
      for (int s = 0; s < 16; s++)
        mdl[j][s] = 24'(j*16 + s);
    pack();
    drain_start = 1'b1;
    out_ready   = 1'b1;
    tick();
    drain_start = 1'b0;
    for (int s = 0; s < 8; s++) begin
      @(negedge clk);
      chk_beat("mid", s);
      tick();
    end
    rst_n = 1'b0;
    #1;
    chk("mrst_valid", out_valid, 0);
    chk("mrst_busy", drain_busy, 0);
    chk("mrst_slot", out_slot, 0);
    chk("mrst_data", out_data, 0);
    @(negedge clk);
    chk("mrst_done", drain_done, 0);
    tick();
    rst_n = 1'b1;
    @(negedge clk);
    chk("mrst_done_after", drain_done, 0);
    chk("mrst_valid_after", out_valid, 0);
    tick();
    stream_all("fresh", 1'b0, 1'b0);
    tick();

    // RELU handling of a negative lane value
    for (int j = 0; j < 16; j++)
      for (int s = 0; s < 16; s++)
        mdl[j][s] = 24'h0;
    mdl[3][2] = 24'h800001;
    mdl[4][2] = 24'h000005;
    pack();
    stream_all("relu", 1'b0, 1'b1);
    tick();

    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/psum_drain.md
# psum_drain

Read-side drain for the 16-lane MAC accumulator array. On a start request it snapshots the full 6144-bit partial-sum latch array (16 lanes x 16 slots x 24 bits) and streams it out one slot per beat, all 16 lanes side by side, over a valid/ready interface toward the output buffer. The snapshot frees the MAC array to begin the next accumulation pass immediately.

## Interface
- LANES, 16, number of MAC lanes (fixed; other values unsupported)
- SLOTS, 16, accumulator slots per lane (fixed)
- PSUM_W, 24, partial-sum width in bits, two's complement
- clk  in  1  single clock, all state on rising edge
- rst_n  in  1  reset, asynchronous, active-low
- latch_array_in  in  6144  accumulator array; lane j slot s at bits [j*384 + s*24 + 23 -: 24]
- drain_start  in  1  request snapshot and drain; sampled only in IDLE
- drain_busy  out  1  high in STREAM
- out_valid  out  1  beat available
- out_ready  in  1  consumer accepts beat
- out_data  out  384  beat payload; lane j at bits [j*24 + 23 -: 24]
- out_slot  out  4  slot index of current beat
- out_last  out  1  high on the slot-15 beat
- drain_done  out  1  one-cycle pulse after the last beat transfers

## Operation
- States: IDLE, STREAM.
- IDLE: drain_start=1 at a rising edge -> snapshot register loads latch_array_in, slot counter <= 0, state <= STREAM.
- STREAM: out_valid=1; out_data = snapshot lane 0..15 at slot out_slot; out_last = (out_slot == 15).
- Transfer = out_valid && out_ready at a rising edge. Transfer with slot < 15 -> slot+1. Transfer with slot == 15 -> state <= IDLE, drain_done <= 1 for exactly one cycle.
- No transfer -> out_data, out_slot, out_last held stable.
- drain_start in STREAM ignored (not queued); latch_array_in changes after capture do not affect the stream.
- Slot counter never wraps in-stream; 16 beats per drain, in order 0..15.

## Timing
- Reset: state IDLE; out_valid, out_last, drain_busy, drain_done = 0; out_slot = 0; out_data = 0; snapshot = 0.
- Latency: drain_start sampled at edge N -> out_valid=1 with slot 0 after edge N.
- Minimum drain: 16 cycles with out_ready held high; drain_done high during cycle following the slot-15 transfer.
- drain_start high in the drain_done cycle (IDLE) is accepted; back-to-back drains have one idle cycle between slot-15 beat and the next slot-0 beat.
- out_ready ignored while out_valid=0.
- rst_n asserted mid-stream: immediate return to reset values; partial drain discarded, no drain_done.
- Output path fully registered; no combinational path from out_ready or drain_start to any output.

## Configuration
- PSUM_DRAIN_RELU_EN defined: each 24-bit lane value with sign bit set is replaced by 0 in out_data (applied at output; snapshot unchanged).
- Not defined: values passed through bit-exact, signed.

## Test plan
- Reset: rst_n=0 then release -> all outputs 0, state IDLE, out_valid=0 for 5 idle cycles with out_ready=1.
- Basic drain: lane j slot s = j*16+s, drain_start one cycle, out_ready=1 -> 16 consecutive beats, beat s lane j = j*16+s, out_last only on beat 15, drain_done one cycle after.
- Backpressure: out_ready toggled 1,0,0,1 pattern -> no beat dropped or duplicated, data stable while stalled, 16 beats total.
- Snapshot isolation: overwrite latch_array_in with 24'hFFFFFF one cycle after start -> streamed values are the captured originals; drain_start pulses mid-stream have no effect.
- Mid-stream reset: assert rst_n=0 after beat 7 -> out_valid falls immediately, no drain_done; fresh drain afterwards starts at slot 0.
- RELU: lane 3 slot 2 = 24'h800001, lane 4 slot 2 = 24'h000005 -> with PSUM_DRAIN_RELU_EN 0 and 5; without it 24'h800001 and 5.
